// File: rtl/collision_scan_ctrl_pkg.sv
// Shared constants and state encoding for the frog/car collision scan path.
package collision_scan_ctrl_pkg;

    localparam int unsigned DEF_TILE_SIZE = 32;
    localparam int unsigned COORD_W       = 10;
    localparam int unsigned CAR_Y_W       = 9;
    // One extra bit so coordinate + tile size never wraps
    localparam int unsigned OVL_W         = COORD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } scan_state_e;

endpackage

// File: rtl/collision_scan_ctrl_if.sv
// Car-position store read port: strobe + slot index out, position back one cycle later.
interface collision_scan_ctrl_if
    import collision_scan_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = 2
);
    logic               o_Car_Rd;
    logic [IDX_W-1:0]   o_Car_Idx;
    logic [COORD_W-1:0] i_Car_X;
    logic [CAR_Y_W-1:0] i_Car_Y;

    modport master (output o_Car_Rd, o_Car_Idx, input  i_Car_X, i_Car_Y);
    modport slave  (input  o_Car_Rd, o_Car_Idx, output i_Car_X, i_Car_Y);
endinterface

// File: rtl/collision_scan_ctrl_aabb.sv
// Strict axis-aligned overlap test of two equal square tiles; touching edges are not a hit.
module aabb_overlap #(
    parameter int unsigned TILE_SIZE = 32,
    parameter int unsigned W         = 11
) (
    input  logic [W-1:0] a_x,
    input  logic [W-1:0] a_y,
    input  logic [W-1:0] b_x,
    input  logic [W-1:0] b_y,
    output logic         overlap_c
);
    localparam logic [W-1:0] TILE = W'(TILE_SIZE);

    assign overlap_c = (a_x < b_x + TILE) && (b_x < a_x + TILE) &&
                       (a_y < b_y + TILE) && (b_y < a_y + TILE);
endmodule

// File: rtl/collision_scan_ctrl.sv
// Once-per-frame scan of all car slots against a latched frog tile, sharing one comparator.
module collision_scan_ctrl
    import collision_scan_ctrl_pkg::*;
#(
    parameter int unsigned TILE_SIZE = DEF_TILE_SIZE,
    parameter int unsigned C_NB_CARS = 4,
    localparam int unsigned IDX_W    = (C_NB_CARS > 1) ? $clog2(C_NB_CARS) : 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Frame_Start,
    input  logic [COORD_W-1:0]    i_Frog_X,
    input  logic [COORD_W-1:0]    i_Frog_Y,
    collision_scan_ctrl_if.master car_bus,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Has_Collided,
    output logic [IDX_W-1:0]      o_Hit_Idx,
    output logic                  o_Overrun
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NB_CARS - 1);

    scan_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COORD_W-1:0] frog_x_q, frog_x_d, frog_y_q, frog_y_d;
    logic               hit_q, hit_d;
    logic [IDX_W-1:0]   hit_idx_acc_q, hit_idx_acc_d;
    logic               car_rd_q, car_rd_d;
    logic [IDX_W-1:0]   car_idx_q, car_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               coll_q, coll_d;
    logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
    logic               overrun_q, overrun_d;
    logic               overlap_c;

    aabb_overlap #(
        .TILE_SIZE (TILE_SIZE),
        .W         (OVL_W)
    ) u_overlap (
        .a_x       (OVL_W'(frog_x_q)),
        .a_y       (OVL_W'(frog_y_q)),
        .b_x       (OVL_W'(car_bus.i_Car_X)),
        .b_y       (OVL_W'(car_bus.i_Car_Y)),
        .overlap_c (overlap_c)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state, scan datapath and next values of every registered output
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        frog_x_d      = frog_x_q;
        frog_y_d      = frog_y_q;
        hit_d         = hit_q;
        hit_idx_acc_d = hit_idx_acc_q;
        coll_d        = coll_q;
        hit_idx_d     = hit_idx_q;
        overrun_d     = i_Frame_Start && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (i_Frame_Start) begin
                    frog_x_d      = i_Frog_X;
                    frog_y_d      = i_Frog_Y;
                    idx_d         = '0;
                    hit_d         = 1'b0;
                    hit_idx_acc_d = '0;
                    state_d       = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_COMPARE;
            ST_COMPARE: begin
                if (overlap_c && !hit_q) begin
                    hit_d         = 1'b1;
                    hit_idx_acc_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with the state cycle
        car_rd_d  = (state_d == ST_FETCH);
        car_idx_d = idx_d;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            coll_d    = hit_d;
            hit_idx_d = hit_idx_acc_d;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            idx_q         <= '0;
            frog_x_q      <= '0;
            frog_y_q      <= '0;
            hit_q         <= 1'b0;
            hit_idx_acc_q <= '0;
            car_rd_q      <= 1'b0;
            car_idx_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            coll_q        <= 1'b0;
            hit_idx_q     <= '0;
            overrun_q     <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            frog_x_q      <= frog_x_d;
            frog_y_q      <= frog_y_d;
            hit_q         <= hit_d;
            hit_idx_acc_q <= hit_idx_acc_d;
            car_rd_q      <= car_rd_d;
            car_idx_q     <= car_idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            coll_q        <= coll_d;
            hit_idx_q     <= hit_idx_d;
            overrun_q     <= overrun_d;
        end
    end

    assign car_bus.o_Car_Rd  = car_rd_q;
    assign car_bus.o_Car_Idx = car_idx_q;
    assign o_Busy            = busy_q;
    assign o_Done            = done_q;
    assign o_Has_Collided    = coll_q;
    assign o_Hit_Idx         = hit_idx_q;
    assign o_Overrun         = overrun_q;
endmodule

// File: tb/tb_collision_scan_ctrl.sv
// Directed bench for collision_scan_ctrl: vector table of scans plus overrun and reset sequences.
module tb_collision_scan_ctrl;
    import collision_scan_ctrl_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned IDXW = 2;

    typedef struct {
        string      name;
        logic [9:0] fx;
        logic [9:0] fy;
        logic [9:0] cx [N];
        logic [8:0] cy [N];
        logic       exp_coll;
        logic [1:0] exp_idx;
    } vec_t;

    logic            i_Clk = 1'b0;
    logic            i_Rst_L = 1'b0;
    logic            i_Frame_Start = 1'b0;
    logic [9:0]      i_Frog_X = '0;
    logic [9:0]      i_Frog_Y = '0;
    logic            o_Busy, o_Done, o_Has_Collided, o_Overrun;
    logic [IDXW-1:0] o_Hit_Idx;

    logic [9:0] car_x [N];
    logic [8:0] car_y [N];
    vec_t       vecs [11];
    int         checks = 0;
    int         failures = 0;
    logic       exp_coll = 1'b0;
    logic [1:0] exp_idx = '0;

    collision_scan_ctrl_if #(.IDX_W(IDXW)) bus ();

    collision_scan_ctrl #(.TILE_SIZE(32), .C_NB_CARS(N)) dut (
        .i_Clk          (i_Clk),
        .i_Rst_L        (i_Rst_L),
        .i_Frame_Start  (i_Frame_Start),
        .i_Frog_X       (i_Frog_X),
        .i_Frog_Y       (i_Frog_Y),
        .car_bus        (bus.master),
        .o_Busy         (o_Busy),
        .o_Done         (o_Done),
        .o_Has_Collided (o_Has_Collided),
        .o_Hit_Idx      (o_Hit_Idx),
        .o_Overrun      (o_Overrun)
    );

    always #5 i_Clk = ~i_Clk;

    // Car-position store model: data appears the cycle after the read strobe
    always @(posedge i_Clk) begin
        if (bus.o_Car_Rd) begin
            bus.i_Car_X <= car_x[bus.o_Car_Idx];
            bus.i_Car_Y <= car_y[bus.o_Car_Idx];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic load_cars(input vec_t v);
        for (int i = 0; i < N; i++) begin
            car_x[i] = v.cx[i];
            car_y[i] = v.cy[i];
        end
    endtask

    function automatic vec_t far_vec(input string name, input logic [9:0] fx, input logic [9:0] fy);
        vec_t v;
        v.name = name; v.fx = fx; v.fy = fy;
        for (int i = 0; i < N; i++) begin
            v.cx[i] = 10'd700;
            v.cy[i] = 9'd400;
        end
        v.exp_coll = 1'b0; v.exp_idx = '0;
        return v;
    endfunction

    // One full scan: checks strobe/index sequence, verdict hold, done latency and result
    task automatic run_scan(input string name, input logic [9:0] fx, input logic [9:0] fy,
                            input logic ec, input logic [1:0] ei);
        int cyc;
        @(negedge i_Clk);
        i_Frog_X = fx; i_Frog_Y = fy; i_Frame_Start = 1'b1;
        @(negedge i_Clk);
        i_Frame_Start = 1'b0;
        cyc = 1;
        while (!o_Done && cyc < 40) begin
            chk({name, ":busy"}, 32'(o_Busy), 32'd1);
            chk({name, ":rd"}, 32'(bus.o_Car_Rd), 32'(cyc % 2));
            if (cyc % 2 == 1) chk({name, ":idx"}, 32'(bus.o_Car_Idx), 32'((cyc - 1) / 2));
            chk({name, ":hold"}, 32'(o_Has_Collided), 32'(exp_coll));
            @(negedge i_Clk);
            cyc++;
        end
        chk({name, ":done_cycle"}, 32'(cyc), 32'(2 * N + 1));
        exp_coll = ec;
        exp_idx  = ec ? ei : 2'd0;
        chk({name, ":collided"}, 32'(o_Has_Collided), 32'(exp_coll));
        chk({name, ":hit_idx"}, 32'(o_Hit_Idx), 32'(exp_idx));
        chk({name, ":busy_done"}, 32'(o_Busy), 32'd1);
        @(negedge i_Clk);
        chk({name, ":done_pulse"}, 32'(o_Done), 32'd0);
        chk({name, ":idle"}, 32'(o_Busy), 32'd0);
        chk({name, ":kept"}, 32'(o_Has_Collided), 32'(exp_coll));
    endtask

    initial begin
        // Stimulus table; unlisted cars sit far away at (700,400)
        vecs[0] = far_vec("multi_hit", 10'd100, 10'd200);
        vecs[0].cx = '{10'd300, 10'd90, 10'd500, 10'd110};
        vecs[0].cy = '{9'd0, 9'd190, 9'd300, 9'd210};
        vecs[0].exp_coll = 1'b1; vecs[0].exp_idx = 2'd1;
        vecs[1] = far_vec("none", 10'd100, 10'd200);
        vecs[2] = far_vec("last_slot", 10'd100, 10'd200);
        vecs[2].cx[3] = 10'd110; vecs[2].cy[3] = 9'd210;
        vecs[2].exp_coll = 1'b1; vecs[2].exp_idx = 2'd3;
        vecs[3] = far_vec("touch_right", 10'd100, 10'd200);
        vecs[3].cx[0] = 10'd132; vecs[3].cy[0] = 9'd200;
        vecs[4] = far_vec("overlap_1px", 10'd100, 10'd200);
        vecs[4].cx[0] = 10'd131; vecs[4].cy[0] = 9'd200;
        vecs[4].exp_coll = 1'b1;
        vecs[5] = far_vec("touch_below", 10'd100, 10'd200);
        vecs[5].cx[0] = 10'd100; vecs[5].cy[0] = 9'd232;
        vecs[6] = far_vec("x_edge_1015", 10'd1015, 10'd0);
        vecs[6].cx[0] = 10'd1000; vecs[6].cy[0] = 9'd0;
        vecs[6].exp_coll = 1'b1;
        vecs[7] = far_vec("no_wrap", 10'd0, 10'd0);
        vecs[7].cx[0] = 10'd1000; vecs[7].cy[0] = 9'd0;
        vecs[8] = far_vec("touch_left", 10'd50, 10'd50);
        vecs[8].cx[0] = 10'd18; vecs[8].cy[0] = 9'd50;
        vecs[9] = far_vec("car_y_high", 10'd0, 10'd480);
        vecs[9].cx[0] = 10'd0; vecs[9].cy[0] = 9'd500;
        vecs[9].exp_coll = 1'b1;
        vecs[10] = far_vec("touch_above", 10'd100, 10'd200);
        vecs[10].cx[1] = 10'd69;  vecs[10].cy[1] = 9'd200;
        vecs[10].cx[2] = 10'd100; vecs[10].cy[2] = 9'd168;
        vecs[10].exp_coll = 1'b1; vecs[10].exp_idx = 2'd1;

        // Reset state, then idle with no stimulus
        repeat (3) @(negedge i_Clk);
        chk("rst:busy", 32'(o_Busy), 32'd0);
        chk("rst:done", 32'(o_Done), 32'd0);
        chk("rst:collided", 32'(o_Has_Collided), 32'd0);
        chk("rst:hit_idx", 32'(o_Hit_Idx), 32'd0);
        chk("rst:overrun", 32'(o_Overrun), 32'd0);
        chk("rst:rd", 32'(bus.o_Car_Rd), 32'd0);
        i_Rst_L = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_Clk);
            chk("idle:busy", 32'(o_Busy), 32'd0);
            chk("idle:done", 32'(o_Done), 32'd0);
        end

        foreach (vecs[i]) begin
            load_cars(vecs[i]);
            run_scan(vecs[i].name, vecs[i].fx, vecs[i].fy, vecs[i].exp_coll, vecs[i].exp_idx);
        end

        // Overrun mid-scan and during DONE; frog moved mid-scan must be ignored
        load_cars(vecs[0]);
        @(negedge i_Clk);
        i_Frog_X = 10'd100; i_Frog_Y = 10'd200; i_Frame_Start = 1'b1;
        @(negedge i_Clk);
        i_Frame_Start = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            chk($sformatf("ovr:overrun@%0d", cyc), 32'(o_Overrun), 32'(cyc == 4 || cyc == 10));
            chk($sformatf("ovr:done@%0d", cyc), 32'(o_Done), 32'(cyc == 9));
            chk($sformatf("ovr:busy@%0d", cyc), 32'(o_Busy), 32'(cyc <= 9));
            chk($sformatf("ovr:coll@%0d", cyc), 32'(o_Has_Collided), 32'(cyc >= 9 ? 1'b1 : exp_coll));
            if (cyc == 2) begin
                i_Frog_X = 10'd600; i_Frog_Y = 10'd400;
            end
            i_Frame_Start = (cyc == 3 || cyc == 9);
            @(negedge i_Clk);
        end
        exp_coll = 1'b1; exp_idx = 2'd1;
        chk("ovr:hit_idx", 32'(o_Hit_Idx), 32'd1);

        // Reset mid-scan aborts and clears the verdict
        run_scan("pre_rst", 10'd100, 10'd200, 1'b1, 2'd1);
        @(negedge i_Clk);
        i_Frame_Start = 1'b1;
        @(negedge i_Clk);
        i_Frame_Start = 1'b0;
        repeat (3) @(negedge i_Clk);
        i_Rst_L = 1'b0;
        #1;
        chk("abort:busy", 32'(o_Busy), 32'd0);
        chk("abort:collided", 32'(o_Has_Collided), 32'd0);
        chk("abort:hit_idx", 32'(o_Hit_Idx), 32'd0);
        chk("abort:rd", 32'(bus.o_Car_Rd), 32'd0);
        chk("abort:idx", 32'(bus.o_Car_Idx), 32'd0);
        exp_coll = 1'b0; exp_idx = '0;
        repeat (2) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_Clk);
            chk("abort:no_done", 32'(o_Done), 32'd0);
            chk("abort:idle", 32'(o_Busy), 32'd0);
        end
        load_cars(vecs[1]);
        run_scan("post_rst", 10'd100, 10'd200, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
